// File: rtl/mpu_check_arb.sv
// MPU check arbiter: grants fetch or LSU, issues one MPU check at a time, returns the verdict.
// Define MPU_ARB_FAULT_LOG_EN to add a sticky first-fault log (fault_valid/addr/cause, fault_clr).

package mpu_check_arb_pkg;
    typedef enum logic [1:0] {
        PRIV_U = 2'b00,
        PRIV_S = 2'b01,
        PRIV_M = 2'b11
    } priv_e;
endpackage

module mpu_check_arb
    import mpu_check_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned MPU_LAT      = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  priv_e       cur_priv,

    input  logic        if_req_valid,
    input  logic [31:0] if_req_addr,
    output logic        if_req_ready,
    output logic        if_rsp_valid,
    output logic        if_rsp_allow,

    input  logic        lsu_req_valid,
    input  logic [31:0] lsu_req_addr,
    input  logic        lsu_req_we,
    output logic        lsu_req_ready,
    output logic        lsu_rsp_valid,
    output logic        lsu_rsp_allow,

`ifdef MPU_ARB_FAULT_LOG_EN
    output logic        fault_valid,
    output logic [31:0] fault_addr,
    output logic [1:0]  fault_cause,
    input  logic        fault_clr,
`endif

    output logic [31:0] mpu_addr,
    output logic        mpu_is_fetch,
    output logic        mpu_is_load,
    output logic        mpu_is_store,
    output priv_e       mpu_priv,
    input  logic        mpu_allow
);

    localparam int unsigned StarveW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam int unsigned LatW    = (MPU_LAT > 1) ? $clog2(MPU_LAT) : 1;
    localparam logic [StarveW-1:0] StarveMax = StarveW'(STARVE_LIMIT);
    localparam logic [LatW-1:0]    LatLast   = LatW'(MPU_LAT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait
    } state_e;

    // Access type; encoding doubles as the fault cause code.
    typedef enum logic [1:0] {
        AccNone  = 2'b00,
        AccExec  = 2'b01,
        AccLoad  = 2'b10,
        AccStore = 2'b11
    } acc_e;

    state_e             state_q, state_d;
    acc_e               acc_q;
    logic [31:0]        addr_q;
    priv_e              priv_q;
    logic [StarveW-1:0] starve_q;
    logic [LatW-1:0]    lat_cnt_q;
    logic               if_rsp_valid_q, if_rsp_allow_q;
    logic               lsu_rsp_valid_q, lsu_rsp_allow_q;
    logic               if_wins, grant, wait_done;

    assign if_wins   = if_req_valid && (!lsu_req_valid || (starve_q == StarveMax));
    assign grant     = if_req_ready || lsu_req_ready;
    assign wait_done = (state_q == StWait) && (lat_cnt_q == LatLast);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (if_req_valid || lsu_req_valid) state_d = StIssue;
            StIssue: state_d = StWait;
            StWait:  if (wait_done) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        if_req_ready  = 1'b0;
        lsu_req_ready = 1'b0;
        mpu_is_fetch  = 1'b0;
        mpu_is_load   = 1'b0;
        mpu_is_store  = 1'b0;
        unique case (state_q)
            StIdle: begin
                // Gated by rst so no grant can land in a reset cycle.
                if_req_ready  = !rst && if_wins;
                lsu_req_ready = !rst && lsu_req_valid && !if_wins;
            end
            StIssue: begin
                mpu_is_fetch = (acc_q == AccExec);
                mpu_is_load  = (acc_q == AccLoad);
                mpu_is_store = (acc_q == AccStore);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q          <= '0;
            priv_q          <= PRIV_M;
            acc_q           <= AccNone;
            starve_q        <= '0;
            lat_cnt_q       <= '0;
            if_rsp_valid_q  <= 1'b0;
            if_rsp_allow_q  <= 1'b0;
            lsu_rsp_valid_q <= 1'b0;
            lsu_rsp_allow_q <= 1'b0;
        end else begin
            if_rsp_valid_q  <= 1'b0;
            lsu_rsp_valid_q <= 1'b0;

            if (grant) begin
                addr_q <= if_req_ready ? if_req_addr : lsu_req_addr;
                priv_q <= cur_priv;
                if (if_req_ready) begin
                    acc_q <= AccExec;
                end else if (lsu_req_we) begin
                    acc_q <= AccStore;
                end else begin
                    acc_q <= AccLoad;
                end
            end

            // Only losses while IF is actually waiting count toward starvation.
            if (if_req_ready) begin
                starve_q <= '0;
            end else if (lsu_req_ready && if_req_valid && (starve_q != StarveMax)) begin
                starve_q <= starve_q + StarveW'(1);
            end

            if (state_q == StIssue) begin
                lat_cnt_q <= '0;
            end else if (state_q == StWait) begin
                lat_cnt_q <= lat_cnt_q + LatW'(1);
            end

            if (wait_done) begin
                if (acc_q == AccExec) begin
                    if_rsp_valid_q <= 1'b1;
                    if_rsp_allow_q <= mpu_allow;
                end else begin
                    lsu_rsp_valid_q <= 1'b1;
                    lsu_rsp_allow_q <= mpu_allow;
                end
            end
        end
    end

    assign mpu_addr      = addr_q;
    assign mpu_priv      = priv_q;
    assign if_rsp_valid  = if_rsp_valid_q;
    assign if_rsp_allow  = if_rsp_allow_q;
    assign lsu_rsp_valid = lsu_rsp_valid_q;
    assign lsu_rsp_allow = lsu_rsp_allow_q;

`ifdef MPU_ARB_FAULT_LOG_EN
    logic        fault_valid_q;
    logic [31:0] fault_addr_q;
    logic [1:0]  fault_cause_q;
    logic        fault_new;

    assign fault_new = wait_done && !mpu_allow;

    // A clear in the same cycle as a new fault lets the new fault through.
    always_ff @(posedge clk) begin
        if (rst) begin
            fault_valid_q <= 1'b0;
            fault_addr_q  <= '0;
            fault_cause_q <= '0;
        end else if (fault_new && (!fault_valid_q || fault_clr)) begin
            fault_valid_q <= 1'b1;
            fault_addr_q  <= addr_q;
            fault_cause_q <= acc_q;
        end else if (fault_clr) begin
            fault_valid_q <= 1'b0;
        end
    end

    assign fault_valid = fault_valid_q;
    assign fault_addr  = fault_addr_q;
    assign fault_cause = fault_cause_q;
`endif

endmodule

// File: tb/tb_mpu_check_arb.sv
// Randomized bench for mpu_check_arb against a cycle-count model of the grant/issue/response flow.
// Fault-log checks are compiled in when MPU_ARB_FAULT_LOG_EN is defined.

module tb_mpu_check_arb;
    import mpu_check_arb_pkg::*;

    localparam int unsigned STARVE_LIMIT = 4;
    localparam int unsigned MPU_LAT      = 2;
    localparam int          RSP          = MPU_LAT + 2;  // cycles after grant at which the response shows

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    priv_e       cur_priv = PRIV_M;
    logic        if_req_valid = 1'b0;
    logic [31:0] if_req_addr = '0;
    logic        if_req_ready, if_rsp_valid, if_rsp_allow;
    logic        lsu_req_valid = 1'b0;
    logic [31:0] lsu_req_addr = '0;
    logic        lsu_req_we = 1'b0;
    logic        lsu_req_ready, lsu_rsp_valid, lsu_rsp_allow;
    logic [31:0] mpu_addr;
    logic        mpu_is_fetch, mpu_is_load, mpu_is_store;
    priv_e       mpu_priv;
    logic        mpu_allow = 1'b0;
`ifdef MPU_ARB_FAULT_LOG_EN
    logic        fault_valid;
    logic [31:0] fault_addr;
    logic [1:0]  fault_cause;
    logic        fault_clr = 1'b0;
`endif

    always #5 clk = ~clk;

    mpu_check_arb #(
        .STARVE_LIMIT(STARVE_LIMIT),
        .MPU_LAT     (MPU_LAT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cur_priv     (cur_priv),
        .if_req_valid (if_req_valid),
        .if_req_addr  (if_req_addr),
        .if_req_ready (if_req_ready),
        .if_rsp_valid (if_rsp_valid),
        .if_rsp_allow (if_rsp_allow),
        .lsu_req_valid(lsu_req_valid),
        .lsu_req_addr (lsu_req_addr),
        .lsu_req_we   (lsu_req_we),
        .lsu_req_ready(lsu_req_ready),
        .lsu_rsp_valid(lsu_rsp_valid),
        .lsu_rsp_allow(lsu_rsp_allow),
`ifdef MPU_ARB_FAULT_LOG_EN
        .fault_valid  (fault_valid),
        .fault_addr   (fault_addr),
        .fault_cause  (fault_cause),
        .fault_clr    (fault_clr),
`endif
        .mpu_addr     (mpu_addr),
        .mpu_is_fetch (mpu_is_fetch),
        .mpu_is_load  (mpu_is_load),
        .mpu_is_store (mpu_is_store),
        .mpu_priv     (mpu_priv),
        .mpu_allow    (mpu_allow)
    );

    int checks = 0;
    int errors = 0;

    // Model state: cycles since the in-flight grant (0 = nothing in flight).
    int          m_since = 0;
    int          m_starve = 0;
    logic        m_if = 1'b0;
    logic [1:0]  m_acc = 2'd0;  // 1 exec, 2 load, 3 store
    logic [31:0] m_addr = '0;
    priv_e       m_priv = PRIV_M;
    logic        m_verdict = 1'b0;
    byte         grant_log[$];
    byte         last_grant = 8'h00;
`ifdef MPU_ARB_FAULT_LOG_EN
    logic        m_fv = 1'b0;
    logic [31:0] m_fa = '0;
    logic [1:0]  m_fc = '0;
    logic        n_fclr = 1'b0;
`endif

    // Next-cycle input values, applied just after each rising edge.
    logic        n_rst = 1'b1;
    priv_e       n_priv = PRIV_M;
    logic        n_if_v = 1'b0, n_lsu_v = 1'b0, n_lsu_we = 1'b0;
    logic [31:0] n_if_a = '0, n_lsu_a = '0;
    bit          rand_mode = 1'b0;
    bit          if_pend = 1'b0, lsu_pend = 1'b0;

    // The bench's MPU: machine mode sees everything; others lose the top half, stores lose bit 30.
    function automatic logic mpu_rule(logic [31:0] a, priv_e p, logic [1:0] acc);
        return (p == PRIV_M) || (!a[31] && !((acc == 2'd3) && a[30]));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic priv_e pick_priv();
        case ($urandom_range(0, 2))
            0:       return PRIV_U;
            1:       return PRIV_S;
            default: return PRIV_M;
        endcase
    endfunction

    task automatic gen_stim();
        if (!if_pend) begin
            if ($urandom_range(0, 2) == 0) begin
                if_pend = 1'b1;
                n_if_a  = $urandom;
            end
        end else if ($urandom_range(0, 19) == 0) begin
            if_pend = 1'b0;
        end
        n_if_v = if_pend;
        if (!lsu_pend) begin
            if ($urandom_range(0, 1) == 0) begin
                lsu_pend = 1'b1;
                n_lsu_a  = $urandom;
                n_lsu_we = 1'($urandom_range(0, 1));
            end
        end else if ($urandom_range(0, 19) == 0) begin
            lsu_pend = 1'b0;
        end
        n_lsu_v = lsu_pend;
        n_priv  = pick_priv();
        n_rst   = ($urandom_range(0, 149) == 0);
`ifdef MPU_ARB_FAULT_LOG_EN
        n_fclr  = ($urandom_range(0, 29) == 0);
`endif
    endtask

    task automatic check_and_update();
        bit         idle, e_if_rdy, e_lsu_rdy, rsp_now, fault_now;
        logic [2:0] e_is;
        idle      = (m_since == 0) || (m_since == RSP);
        rsp_now   = (m_since == RSP);
        e_if_rdy  = 1'b0;
        e_lsu_rdy = 1'b0;
        if (idle && !rst) begin
            if (if_req_valid && (!lsu_req_valid || m_starve == STARVE_LIMIT)) e_if_rdy = 1'b1;
            else if (lsu_req_valid) e_lsu_rdy = 1'b1;
        end
        chk("if_req_ready", 32'(if_req_ready), 32'(e_if_rdy));
        chk("lsu_req_ready", 32'(lsu_req_ready), 32'(e_lsu_rdy));
        chk("if_rsp_valid", 32'(if_rsp_valid), 32'(rsp_now && m_if));
        chk("lsu_rsp_valid", 32'(lsu_rsp_valid), 32'(rsp_now && !m_if));
        if (rsp_now && m_if) chk("if_rsp_allow", 32'(if_rsp_allow), 32'(m_verdict));
        if (rsp_now && !m_if) chk("lsu_rsp_allow", 32'(lsu_rsp_allow), 32'(m_verdict));
        e_is = 3'b000;
        if (m_since == 1) e_is = (m_acc == 2'd1) ? 3'b100 : (m_acc == 2'd2) ? 3'b010 : 3'b001;
        chk("mpu_is", 32'({mpu_is_fetch, mpu_is_load, mpu_is_store}), 32'(e_is));
        if (m_since == 1) begin
            chk("mpu_addr", mpu_addr, m_addr);
            chk("mpu_priv", 32'(mpu_priv), 32'(m_priv));
        end
`ifdef MPU_ARB_FAULT_LOG_EN
        chk("fault_valid", 32'(fault_valid), 32'(m_fv));
        if (m_fv) begin
            chk("fault_addr", fault_addr, m_fa);
            chk("fault_cause", 32'(fault_cause), 32'(m_fc));
        end
`endif
        last_grant = 8'h00;
        if (rst) begin
            m_since  = 0;
            m_starve = 0;
            m_addr   = '0;
            m_priv   = PRIV_M;
`ifdef MPU_ARB_FAULT_LOG_EN
            m_fv = 1'b0;
`endif
        end else begin
            fault_now = (m_since == RSP - 1) && !m_verdict;
`ifdef MPU_ARB_FAULT_LOG_EN
            if (fault_now && (!m_fv || fault_clr)) begin
                m_fv = 1'b1;
                m_fa = m_addr;
                m_fc = m_acc;
            end else if (fault_clr) begin
                m_fv = 1'b0;
            end
`endif
            if (m_since != 0) m_since = (m_since == RSP) ? 0 : m_since + 1;
            if (e_if_rdy || e_lsu_rdy) begin
                m_since   = 1;
                m_if      = e_if_rdy;
                m_addr    = e_if_rdy ? if_req_addr : lsu_req_addr;
                m_priv    = cur_priv;
                m_acc     = e_if_rdy ? 2'd1 : (lsu_req_we ? 2'd3 : 2'd2);
                m_verdict = mpu_rule(m_addr, m_priv, m_acc);
                last_grant = e_if_rdy ? 8'h49 : 8'h4C;
                grant_log.push_back(last_grant);
            end
            if (e_if_rdy) begin
                m_starve = 0;
                if_pend  = 1'b0;
            end
            if (e_lsu_rdy) begin
                lsu_pend = 1'b0;
                if (if_req_valid && m_starve < STARVE_LIMIT) m_starve++;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_mode) gen_stim();
        rst           = n_rst;
        cur_priv      = n_priv;
        if_req_valid  = n_if_v;
        if_req_addr   = n_if_a;
        lsu_req_valid = n_lsu_v;
        lsu_req_addr  = n_lsu_a;
        lsu_req_we    = n_lsu_we;
`ifdef MPU_ARB_FAULT_LOG_EN
        fault_clr     = n_fclr;
`endif
        // Garbage outside the verdict cycle catches sampling at the wrong time.
        mpu_allow = (m_since == RSP - 1) ? m_verdict : 1'($urandom_range(0, 1));
        @(negedge clk);
        check_and_update();
    endtask

    task automatic do_req(input bit is_if, input logic [31:0] a, input bit we, input priv_e p);
        int  n;
        byte want;
        n    = 0;
        want = is_if ? 8'h49 : 8'h4C;
        n_priv = p;
        if (is_if) begin
            n_if_v = 1'b1;
            n_if_a = a;
        end else begin
            n_lsu_v  = 1'b1;
            n_lsu_a  = a;
            n_lsu_we = we;
        end
        do begin
            step();
            n++;
        end while (last_grant != want && n < 20);
        chk("grant_seen", 32'(last_grant), 32'(want));
        n_if_v  = 1'b0;
        n_lsu_v = 1'b0;
    endtask

    task automatic wait_rsp(input bit is_if, output int n, output logic allow);
        n = 0;
        do begin
            step();
            n++;
        end while (!(is_if ? if_rsp_valid : lsu_rsp_valid) && n < 20);
        allow = is_if ? if_rsp_allow : lsu_rsp_allow;
    endtask

    initial begin
        int    n;
        logic  al;
        string pat;

        // Reset values.
        n_rst = 1'b1;
        repeat (2) step();
        n_rst = 1'b0;
        step();
        chk("rst_if_allow", 32'(if_rsp_allow), 32'd0);
        chk("rst_lsu_allow", 32'(lsu_rsp_allow), 32'd0);
        chk("rst_mpu_addr", mpu_addr, 32'd0);
        chk("rst_mpu_priv", 32'(mpu_priv), 32'(PRIV_M));
        chk("rst_mpu_is", 32'({mpu_is_fetch, mpu_is_load, mpu_is_store}), 32'd0);

        // Denied user load to the top half.
        do_req(1'b0, 32'h8000_0000, 1'b0, PRIV_U);
        step();
        chk("load_is_load", 32'(mpu_is_load), 32'd1);
        chk("load_addr", mpu_addr, 32'h8000_0000);
        wait_rsp(1'b0, n, al);
        chk("load_rsp_lat", n, MPU_LAT + 1);
        chk("load_allow", 32'(al), 32'd0);

        // Allowed fetch.
        do_req(1'b1, 32'h0000_0100, 1'b0, PRIV_U);
        step();
        chk("fetch_is_fetch", 32'(mpu_is_fetch), 32'd1);
        wait_rsp(1'b1, n, al);
        chk("fetch_rsp_lat", n, MPU_LAT + 1);
        chk("fetch_allow", 32'(al), 32'd1);

        // Both requesters held: starvation forces every fifth grant to IF.
        grant_log.delete();
        n_priv  = PRIV_M;
        n_if_v  = 1'b1;
        n_if_a  = 32'h0000_0200;
        n_lsu_v = 1'b1;
        n_lsu_a = 32'h0000_0300;
        repeat (10 * RSP) step();
        n_if_v  = 1'b0;
        n_lsu_v = 1'b0;
        repeat (RSP) step();
        pat = "LLLLILLLLI";
        chk("starve_count", 32'(grant_log.size() >= 10), 32'd1);
        for (int i = 0; i < 10; i++) begin
            if (i < grant_log.size()) chk("starve_order", 32'(grant_log[i]), 32'(pat[i]));
        end

        // Reset in the last wait cycle discards the check; first grant right after.
        do_req(1'b0, 32'h0000_2000, 1'b1, PRIV_S);
        step();
        step();
        n_rst    = 1'b1;
        n_lsu_v  = 1'b1;
        n_lsu_a  = 32'h0000_3000;
        n_lsu_we = 1'b0;
        step();
        n_rst = 1'b0;
        step();
        chk("rstw_lsu_rsp", 32'(lsu_rsp_valid), 32'd0);
        chk("rstw_if_rsp", 32'(if_rsp_valid), 32'd0);
        chk("rstw_mpu_addr", mpu_addr, 32'd0);
        chk("rstw_mpu_priv", 32'(mpu_priv), 32'(PRIV_M));
        chk("rstw_if_allow", 32'(if_rsp_allow), 32'd0);
        chk("rstw_grant", 32'(lsu_req_ready), 32'd1);
        n_lsu_v = 1'b0;
        repeat (RSP) step();

`ifdef MPU_ARB_FAULT_LOG_EN
        n_fclr = 1'b1;
        step();
        n_fclr = 1'b0;
        do_req(1'b0, 32'h8000_0010, 1'b1, PRIV_U);
        wait_rsp(1'b0, n, al);
        do_req(1'b0, 32'h8000_0020, 1'b0, PRIV_U);
        wait_rsp(1'b0, n, al);
        step();
        chk("flog_valid", 32'(fault_valid), 32'd1);
        chk("flog_addr", fault_addr, 32'h8000_0010);
        chk("flog_cause", 32'(fault_cause), 32'd3);
        n_fclr = 1'b1;
        step();
        n_fclr = 1'b0;
        step();
        chk("flog_cleared", 32'(fault_valid), 32'd0);
`endif

        // Randomized traffic, cancellations, privilege changes and resets.
        if_pend   = 1'b0;
        lsu_pend  = 1'b0;
        rand_mode = 1'b1;
        repeat (3000) step();
        rand_mode = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

endmodule
